ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
Two-port arbiter that shares the single-port 2048x16 data RAM between requester A (BIP CPU data port) and requester B (loader/debug port). Uses a combinational req/gnt handshake with one RAM access per cycle. Arbitration is round-robin, with optional locked bursts bounded by MAX_BURST. Read data is registered and returned one cycle after the grant.

Parameters:
ADDR_W, 11, RAM address width (2048 words)
DATA_W, 16, RAM data width
MAX_BURST, 4, max consecutive locked grants to one port while the other waits (>=1)

Ports:
clk_i  in  1  clock; all state on posedge
rst_ni  in  1  reset, asynchronous, active-low
a_req_i  in  1  port A access request
a_lock_i  in  1  port A requests locked burst
a_wr_i  in  1  port A 1=write, 0=read
a_addr_i  in  ADDR_W  port A address
a_data_i  in  DATA_W  port A write data
a_gnt_o  out  1  port A granted this cycle
a_rvalid_o  out  1  port A read data valid
a_data_o  out  DATA_W  port A read data
b_req_i, b_lock_i, b_wr_i, b_addr_i, b_data_i, b_gnt_o, b_rvalid_o, b_data_o  same as port A, for port B
ram_enram_o  out  1  to RAM enram_i
ram_wrram_o  out  1  to RAM wrram_i
ram_addr_o  out  ADDR_W  to RAM addr_i
ram_data_o  out  DATA_W  to RAM data_i
ram_data_i  in  DATA_W  from RAM data_o (combinational read of ram_addr_o)

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: state=IDLE, burst_cnt=0, rr_ptr=A, a/b_rvalid_o=0, a/b_data_o=0.
- While rst_ni is low, a/b_gnt_o=0 and ram_enram_o=0, forced combinationally.
- Handshake:
  - Grant is combinational from req, lock, state, rr_ptr and burst_cnt.
  - A transfer occurs at the posedge where req=1 and gnt=1.
  - The requester holds wr/addr/data stable while req=1 and gnt=0.
  - At most one gnt is high per cycle.
- RAM drive:
  - ram_enram_o = a_gnt_o | b_gnt_o.
  - ram_wrram_o, ram_addr_o, ram_data_o are muxed from the granted port.
  - With no grant: ram_wrram_o=0, ram_addr_o=0, ram_data_o=0.
- Read latency:
  - On a granted read, ram_data_i is captured into that port's data_o at the posedge.
  - That port's rvalid_o is 1 for exactly the next cycle.
  - data_o holds its value until the next read by that port.
  - Writes never assert rvalid.
- States:
  - IDLE:
    - Only one req: grant it.
    - Both req: grant the port rr_ptr points to.
    - Granted port X with lock=1: go to LOCK_X, burst_cnt=1.
  - LOCK_X (X=A or B):
    - If req_X=1, lock_X=1 and burst_cnt<MAX_BURST: grant only X; burst_cnt+1 on transfer; the other port waits.
    - Otherwise: the cycle behaves as IDLE with rr_ptr pointing to the other port; state leaves LOCK_X at the posedge.
    - If X is regranted with lock=1 in that IDLE-behaving cycle (the other port not requesting), re-enter LOCK_X with burst_cnt=1.
- rr_ptr: after any transfer by X, rr_ptr=other port.
- burst_cnt saturates at MAX_BURST; it is cleared on return to IDLE.
- A lock asserted without req is ignored.
- Write-then-read: a write at edge n followed by a read of the same address at edge n+1 (either port) returns the new data. The RAM writes at the edge and reads combinationally.
- Reset mid-burst: grants drop immediately and all state returns to reset values. A transfer in flight at the reset edge is not guaranteed to complete.

Test Plan:
1. B writes 0x1234 @0x005, then A reads @0x005 alone -> a_gnt_o=1 same cycle; next cycle a_rvalid_o=1, a_data_o=0x1234; b_rvalid_o stays 0.
2. After reset, A and B request reads continuously with lock=0 -> grants A,B,A,B...; first grant to A; never both gnt high.
3. MAX_BURST=4; A req+lock held, B req held -> A granted 4 cycles, B 1 cycle, then A enters a new lock (burst of 4).
4. A req+lock for 10 cycles, B idle -> A granted all 10 cycles; burst_cnt restarts at 1 after reaching 4.
5. A drops lock at its 2nd locked transfer while B waits -> B granted the next cycle; rr_ptr=A afterwards.
6. rst_ni low mid-burst -> a/b_gnt_o and ram_enram_o go 0 without a clock edge; rvalid=0; after release both request -> A granted first, state=IDLE.

Source files
------------

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between requesters A and B.
// Supports locked bursts of up to MAX_BURST grants; read data returns one cycle after the grant.
module ram_arbiter #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              a_req_i,
    input  logic              a_lock_i,
    input  logic              a_wr_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_data_i,
    output logic              a_gnt_o,
    output logic              a_rvalid_o,
    output logic [DATA_W-1:0] a_data_o,
    input  logic              b_req_i,
    input  logic              b_lock_i,
    input  logic              b_wr_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              b_gnt_o,
    output logic              b_rvalid_o,
    output logic [DATA_W-1:0] b_data_o,
    output logic              ram_enram_o,
    output logic              ram_wrram_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_data_i
);

    localparam int                CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic               rr_ptr_q, rr_ptr_d;   // 0 = A next, 1 = B next
    logic               eff_rr;
    logic               hold_a, hold_b;
    logic               gnt_a_raw, gnt_b_raw;

    logic               a_rvld_p1, b_rvld_p1;
    logic [DATA_W-1:0]  a_rdata_p1, b_rdata_p1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            rr_ptr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    always_comb begin
        gnt_a_raw   = 1'b0;
        gnt_b_raw   = 1'b0;
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        eff_rr      = rr_ptr_q;
        hold_a      = (state_q == LOCK_A) && a_req_i && a_lock_i && (burst_cnt_q < MAX_CNT);
        hold_b      = (state_q == LOCK_B) && b_req_i && b_lock_i && (burst_cnt_q < MAX_CNT);

        if (hold_a) begin
            gnt_a_raw   = 1'b1;
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
            rr_ptr_d    = 1'b1;
        end else if (hold_b) begin
            gnt_b_raw   = 1'b1;
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
            rr_ptr_d    = 1'b0;
        end else begin
            // A finished or broken burst hands priority to the port that was kept waiting
            if (state_q == LOCK_A)
                eff_rr = 1'b1;
            else if (state_q == LOCK_B)
                eff_rr = 1'b0;

            if (a_req_i && (!b_req_i || !eff_rr))
                gnt_a_raw = 1'b1;
            else if (b_req_i)
                gnt_b_raw = 1'b1;

            state_d     = IDLE;
            burst_cnt_d = '0;
            if (gnt_a_raw) begin
                rr_ptr_d = 1'b1;
                if (a_lock_i) begin
                    state_d     = LOCK_A;
                    burst_cnt_d = CNT_W'(1);
                end
            end else if (gnt_b_raw) begin
                rr_ptr_d = 1'b0;
                if (b_lock_i) begin
                    state_d     = LOCK_B;
                    burst_cnt_d = CNT_W'(1);
                end
            end
        end
    end

    assign a_gnt_o     = gnt_a_raw & rst_ni;
    assign b_gnt_o     = gnt_b_raw & rst_ni;
    assign ram_enram_o = a_gnt_o | b_gnt_o;

    always_comb begin
        ram_wrram_o = 1'b0;
        ram_addr_o  = '0;
        ram_data_o  = '0;
        if (a_gnt_o) begin
            ram_wrram_o = a_wr_i;
            ram_addr_o  = a_addr_i;
            ram_data_o  = a_data_i;
        end else if (b_gnt_o) begin
            ram_wrram_o = b_wr_i;
            ram_addr_o  = b_addr_i;
            ram_data_o  = b_data_i;
        end
    end

    // Stage p1: read data captured at the grant edge, valid for one cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_rvld_p1  <= 1'b0;
            b_rvld_p1  <= 1'b0;
            a_rdata_p1 <= '0;
            b_rdata_p1 <= '0;
        end else begin
            a_rvld_p1 <= a_gnt_o & ~a_wr_i;
            b_rvld_p1 <= b_gnt_o & ~b_wr_i;
            if (a_gnt_o && !a_wr_i)
                a_rdata_p1 <= ram_data_i;
            if (b_gnt_o && !b_wr_i)
                b_rdata_p1 <= ram_data_i;
        end
    end

    assign a_rvalid_o = a_rvld_p1;
    assign b_rvalid_o = b_rvld_p1;
    assign a_data_o   = a_rdata_p1;
    assign b_data_o   = b_rdata_p1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM and read-data scoreboard.
// Grants are checked per cycle; read data is checked by a monitor popping expected queues.
module tb_ram_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              a_req, a_lock, a_wr, b_req, b_lock, b_wr;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_wdata, b_wdata;
    logic              a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DATA_W-1:0] a_rdata, b_rdata;
    logic              ram_en, ram_wr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    logic [DATA_W-1:0] mem [0:2047];
    logic [DATA_W-1:0] qa[$];
    logic [DATA_W-1:0] qb[$];
    int                tests = 0;
    int                fails = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(4)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .a_req_i(a_req), .a_lock_i(a_lock), .a_wr_i(a_wr), .a_addr_i(a_addr), .a_data_i(a_wdata),
        .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_data_o(a_rdata),
        .b_req_i(b_req), .b_lock_i(b_lock), .b_wr_i(b_wr), .b_addr_i(b_addr), .b_data_i(b_wdata),
        .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_data_o(b_rdata),
        .ram_enram_o(ram_en), .ram_wrram_o(ram_wr), .ram_addr_o(ram_addr),
        .ram_data_o(ram_wdata), .ram_data_i(ram_rdata)
    );

    assign ram_rdata = mem[ram_addr];

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'hA000 + 16'(i);
    end

    always @(posedge clk) begin
        if (ram_en && ram_wr) mem[ram_addr] = ram_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected read data whenever a port presents rvalid
    always @(negedge clk) begin
        if (a_rvalid) begin
            if (qa.size() == 0) chk("a_unexpected_rvalid", 1, 0);
            else chk("a_rdata", a_rdata, qa.pop_front());
        end
        if (b_rvalid) begin
            if (qb.size() == 0) chk("b_unexpected_rvalid", 1, 0);
            else chk("b_rdata", b_rdata, qb.pop_front());
        end
    end

    // One cycle: check grants mid-cycle, queue expected read data, advance past the edge
    task automatic tick(input logic ega, input logic egb, input logic [DATA_W-1:0] erd);
        @(negedge clk);
        chk("a_gnt", a_gnt, ega);
        chk("b_gnt", b_gnt, egb);
        chk("ram_en", ram_en, ega | egb);
        if (ega && !a_wr) qa.push_back(erd);
        if (egb && !b_wr) qb.push_back(erd);
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic req, input logic lock, input logic wr,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] d);
        a_req = req; a_lock = lock; a_wr = wr; a_addr = addr; a_wdata = d;
    endtask

    task automatic set_b(input logic req, input logic lock, input logic wr,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] d);
        b_req = req; b_lock = lock; b_wr = wr; b_addr = addr; b_wdata = d;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0;
        set_a(1, 1, 0, 11'h001, 16'h0);
        set_b(1, 0, 0, 11'h002, 16'h0);
        #3;
        chk("rst_a_gnt", a_gnt, 0);
        chk("rst_b_gnt", b_gnt, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_a_rvalid", a_rvalid, 0);
        chk("rst_b_rvalid", b_rvalid, 0);
        chk("rst_a_data", a_rdata, 0);
        chk("rst_b_data", b_rdata, 0);
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst_ni = 1'b1;

        // B writes, then A reads the same word on the next edge
        set_b(1, 0, 1, 11'h005, 16'h1234);
        tick(0, 1, 16'h0);
        set_b(0, 0, 0, 0, 0);
        set_a(1, 0, 0, 11'h005, 16'h0);
        tick(1, 0, 16'h1234);
        set_a(0, 0, 0, 0, 0);
        tick(0, 0, 16'h0);
        tick(0, 0, 16'h0);
        chk("a_data_hold", a_rdata, 16'h1234);

        // Plain round robin after reset, starting with A
        do_reset();
        set_a(1, 0, 0, 11'h010, 0);
        set_b(1, 0, 0, 11'h020, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 16'hA010);
            tick(0, 1, 16'hA020);
        end

        // A locked burst against a waiting B: 4 A, 1 B, 4 A, 1 B
        set_a(1, 1, 0, 11'h030, 0);
        set_b(1, 0, 0, 11'h040, 0);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 4; j++) tick(1, 0, 16'hA030);
            tick(0, 1, 16'hA040);
        end

        // A alone with lock: continuous grants across burst restarts
        set_b(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) tick(1, 0, 16'hA030);
        set_a(0, 0, 0, 0, 0);
        tick(0, 0, 16'h0);

        // Write-then-read by A at consecutive edges
        set_a(1, 0, 1, 11'h050, 16'h5A5A);
        tick(1, 0, 16'h0);
        set_a(1, 0, 0, 11'h050, 0);
        tick(1, 0, 16'h5A5A);

        // A drops lock after two locked transfers; B waiting gets the next grant
        set_a(1, 1, 0, 11'h031, 0);
        tick(1, 0, 16'hA031);
        set_b(1, 0, 0, 11'h005, 0);
        tick(1, 0, 16'hA031);
        set_a(1, 0, 0, 11'h031, 0);
        tick(0, 1, 16'h1234);
        tick(1, 0, 16'hA031);
        tick(0, 1, 16'h1234);

        // Reset asserted mid-burst
        set_a(1, 1, 0, 11'h060, 0);
        set_b(1, 0, 0, 11'h070, 0);
        tick(1, 0, 16'hA060);
        tick(1, 0, 16'hA060);
        rst_ni = 1'b0;
        #1;
        chk("midrst_a_gnt", a_gnt, 0);
        chk("midrst_b_gnt", b_gnt, 0);
        chk("midrst_ram_en", ram_en, 0);
        chk("midrst_a_rvalid", a_rvalid, 0);
        chk("midrst_a_data", a_rdata, 0);
        qa.delete();
        qb.delete();
        @(posedge clk);
        #1 rst_ni = 1'b1;
        set_a(1, 0, 0, 11'h060, 0);
        tick(1, 0, 16'hA060);
        tick(0, 1, 16'hA070);
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        tick(0, 0, 16'h0);
        tick(0, 0, 16'h0);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
